// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg
// Shared field widths and write-back source codes for the write-back stage
// and its register file. Imported by wb_stage and reg_file.
//
// Optional feature macro used by this slice: REGFILE_BYPASS_EN
// (write-through bypass inside reg_file).
// ---------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int WIDTH_RWSel   = 2;
    localparam int WIDTH_REGMARK = 5;
    localparam int WIDTH_RegWE   = 1;
    localparam int WIDTH_COMPOUT = 1;
    localparam int WIDTH_ALUOUT  = 32;
    localparam int WIDTH_OPENUM  = 32;
    localparam int WIDTH_PC      = 32;

    // Write-back source select codes
    typedef enum logic [WIDTH_RWSel-1:0] {
        RWSEL_ALU  = 2'd0,
        RWSEL_DRAM = 2'd1,
        RWSEL_PC4  = 2'd2,
        RWSEL_COMP = 2'd3
    } rwsel_e;

endpackage

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Integer register file: one synchronous write port, two asynchronous read
// ports. x0 always reads as zero and can never be written.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   -> a read of the register being written this cycle returns
//                the write data (write-through)
//   undefined -> a same-cycle read returns the pre-write contents
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears all regs)
//   we, waddr, wdata write port
//   raddr1, rdata1   read port 1 (combinational)
//   raddr2, rdata2   read port 2 (combinational)
// ---------------------------------------------------------------------------
module reg_file
    import wb_stage_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [WIDTH_REGMARK-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [WIDTH_REGMARK-1:0] raddr1,
    input  logic [WIDTH_REGMARK-1:0] raddr2,
    output logic [XLEN-1:0]          rdata1,
    output logic [XLEN-1:0]          rdata2
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_valid;

    // Writes to x0 or to an index beyond the implemented file are dropped
    assign wr_valid = we && (waddr != '0) && (int'(waddr) < NREG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_valid) begin
            regs[waddr] <= wdata;
        end
    end

    // Read data is forced to zero while reset is held so decode never sees
    // a bypassed value from a not-yet-reset upstream register.
    always_comb begin
        rdata1 = '0;
        if (rst_n && (raddr1 != '0) && (int'(raddr1) < NREG)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_valid && (raddr1 == waddr)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
`else
            rdata1 = regs[raddr1];
`endif
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst_n && (raddr2 != '0) && (int'(raddr2) < NREG)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_valid && (raddr2 == waddr)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
`else
            rdata2 = regs[raddr2];
`endif
        end
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back stage of the five-stage RISC-V pipeline. Selects the
// write-back value from the MEM/WB fields, writes it into the register
// file, serves the two decode read ports and counts retired instructions.
//
// Configuration macro: REGFILE_BYPASS_EN (forwarded to reg_file; enables
// write-through so decode sees this cycle's write-back value).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   pc4          link value (pc+4)
//   RWSel        source select: 0 ALU, 1 load data, 2 pc4, 3 comparator
//   RegWr, RegWe destination index / write enable
//   COMPOut      slt/sltu result, zero-extended when selected
//   ALUOut       ALU result
//   DRAMRd       load data (already extended)
//   Retire       one instruction leaves WB this cycle
//   rR1, rR2     decode read indices
//   rD1, rD2     decode read data
//   wD           selected write-back value (for hazard forwarding)
//   wb_fwd_en    write-back will actually update a register
//   instret      64-bit retired-instruction count
// ---------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [XLEN-1:0]          pc4,
    input  logic [WIDTH_RWSel-1:0]   RWSel,
    input  logic [WIDTH_REGMARK-1:0] RegWr,
    input  logic [WIDTH_RegWE-1:0]   RegWe,
    input  logic [WIDTH_COMPOUT-1:0] COMPOut,
    input  logic [XLEN-1:0]          ALUOut,
    input  logic [XLEN-1:0]          DRAMRd,
    input  logic                     Retire,
    input  logic [WIDTH_REGMARK-1:0] rR1,
    input  logic [WIDTH_REGMARK-1:0] rR2,
    output logic [XLEN-1:0]          rD1,
    output logic [XLEN-1:0]          rD2,
    output logic [XLEN-1:0]          wD,
    output logic                     wb_fwd_en,
    output logic [63:0]              instret
);

    logic [63:0] instret_q;

    // Write-back source mux; valid every cycle independent of RegWe
    always_comb begin
        wD = '0;
        unique case (rwsel_e'(RWSel))
            RWSEL_ALU:  wD = ALUOut;
            RWSEL_DRAM: wD = DRAMRd;
            RWSEL_PC4:  wD = pc4;
            RWSEL_COMP: wD = {{(XLEN-WIDTH_COMPOUT){1'b0}}, COMPOut};
            default:    wD = '0;
        endcase
    end

    assign wb_fwd_en = RegWe[0] && (RegWr != '0);

    // Retire is independent of RegWe: stores and branches count too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (Retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;

    reg_file #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (RegWe[0]),
        .waddr  (RegWr),
        .wdata  (wD),
        .raddr1 (rR1),
        .raddr2 (rR2),
        .rdata1 (rD1),
        .rdata2 (rD2)
    );

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Self-checking bench for wb_stage: directed cases with literal expectations
// followed by randomized traffic, all checked against a behavioural model
// (register array + retire count) by a compare process on every falling edge.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc4;
    logic [1:0]  RWSel;
    logic [4:0]  RegWr;
    logic [0:0]  RegWe;
    logic [0:0]  COMPOut;
    logic [31:0] ALUOut;
    logic [31:0] DRAMRd;
    logic        Retire;
    logic [4:0]  rR1;
    logic [4:0]  rR2;
    logic [31:0] rD1;
    logic [31:0] rD2;
    logic [31:0] wD;
    logic        wb_fwd_en;
    logic [63:0] instret;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;

    wb_stage #(.NREG(32), .XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc4       (pc4),
        .RWSel     (RWSel),
        .RegWr     (RegWr),
        .RegWe     (RegWe),
        .COMPOut   (COMPOut),
        .ALUOut    (ALUOut),
        .DRAMRd    (DRAMRd),
        .Retire    (Retire),
        .rR1       (rR1),
        .rR2       (rR2),
        .rD1       (rD1),
        .rD2       (rD2),
        .wD        (wD),
        .wb_fwd_en (wb_fwd_en),
        .instret   (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Expected write-back value from the source-select rule
    function automatic logic [31:0] exp_wd();
        case (RWSel)
            2'd0:    return ALUOut;
            2'd1:    return DRAMRd;
            2'd2:    return pc4;
            default: return {31'd0, COMPOut};
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] r);
        if (!rst_n || r == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (RegWe[0] && RegWr != 5'd0 && RegWr == r) return exp_wd();
`endif
        return m_regs[r];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 64'd0;
    endtask

    // Model update on the same edge the DUT commits
    always @(posedge clk) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            if (RegWe[0] && RegWr != 5'd0) m_regs[RegWr] = exp_wd();
            if (Retire) m_cnt = m_cnt + 64'd1;
        end
    end

    // Compare process: outputs are meaningful every cycle
    always @(negedge clk) begin
        check("wD", {32'd0, wD}, {32'd0, exp_wd()});
        check("wb_fwd_en", {63'd0, wb_fwd_en}, {63'd0, (RegWe[0] && RegWr != 5'd0)});
        check("rD1", {32'd0, rD1}, {32'd0, exp_rd(rR1)});
        check("rD2", {32'd0, rD2}, {32'd0, exp_rd(rR2)});
        check("instret", instret, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        pc4 = '0; RWSel = '0; RegWr = '0; RegWe = '0; COMPOut = '0;
        ALUOut = '0; DRAMRd = '0; Retire = 1'b0; rR1 = '0; rR2 = '0;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        RWSel = 2'd0; ALUOut = v; RegWr = r; RegWe = 1'b1;
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        check("reset_instret", instret, 64'd0);
        check("reset_rd1", {32'd0, rD1}, 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Source select sweep
        ALUOut = 32'hA; DRAMRd = 32'hB; pc4 = 32'hC; COMPOut = 1'b1;
        RWSel = 2'd0; #1 check("sel_alu",  {32'd0, wD}, 64'hA);
        RWSel = 2'd1; #1 check("sel_dram", {32'd0, wD}, 64'hB);
        RWSel = 2'd2; #1 check("sel_pc4",  {32'd0, wD}, 64'hC);
        RWSel = 2'd3; #1 check("sel_comp", {32'd0, wD}, 64'h1);
        step();

        // x0 protection
        idle_inputs();
        write_reg(5'd0, 32'hDEADBEEF);
        #1 check("x0_fwd_en_wr", {63'd0, wb_fwd_en}, 64'd0);
        step();
        RegWe = 1'b0; rR1 = 5'd0;
        #1 check("x0_read", {32'd0, rD1}, 64'd0);
        check("x0_fwd_en_after", {63'd0, wb_fwd_en}, 64'd0);

        // Write/read hazard on x7
        write_reg(5'd7, 32'h11);
        step();
        write_reg(5'd7, 32'h55); rR2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
        #1 check("hazard_same", {32'd0, rD2}, 64'h55);
`else
        #1 check("hazard_same", {32'd0, rD2}, 64'h11);
`endif
        step();
        RegWe = 1'b0;
        #1 check("hazard_next", {32'd0, rD2}, 64'h55);

        // Back-to-back writes to x3
        rR1 = 5'd3;
        write_reg(5'd3, 32'd1);
        step();
        write_reg(5'd3, 32'd2);
`ifdef REGFILE_BYPASS_EN
        #1 check("b2b_first", {32'd0, rD1}, 64'd2);
`else
        #1 check("b2b_first", {32'd0, rD1}, 64'd1);
`endif
        step();
        RegWe = 1'b0;
        #1 check("b2b_second", {32'd0, rD1}, 64'd2);

        // Retire 3 of 5 cycles, one of them with RegWe=0
        idle_inputs();
        Retire = 1'b1; write_reg(5'd9, 32'h99); step();
        Retire = 1'b0; RegWe = 1'b0; step();
        Retire = 1'b1; step();
        Retire = 1'b1; RegWe = 1'b1; step();
        Retire = 1'b0; RegWe = 1'b0; step();
        #1 check("retire_count", instret, 64'd3);

        // Wrap from all-ones
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.instret_q;
        #1 check("preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        Retire = 1'b1; step();
        Retire = 1'b0;
        #1 check("wrap", instret, 64'd0);

        // Asynchronous reset mid-run after writing x5
        write_reg(5'd5, 32'h1234); rR1 = 5'd5; Retire = 1'b1;
        step();
        idle_inputs(); rR1 = 5'd5;
        #1 check("x5_written", {32'd0, rD1}, 64'h1234);
        #1 rst_n = 1'b0;
        model_clear();
        #1 check("async_rst_rd1", {32'd0, rD1}, 64'd0);
        check("async_rst_instret", instret, 64'd0);
        step();
        step();
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            pc4     = $urandom;
            RWSel   = 2'($urandom_range(0, 3));
            RegWr   = 5'($urandom_range(0, 31));
            RegWe   = 1'($urandom_range(0, 1));
            COMPOut = 1'($urandom_range(0, 1));
            ALUOut  = $urandom;
            DRAMRd  = $urandom;
            Retire  = 1'($urandom_range(0, 1));
            rR1     = ($urandom_range(0, 3) == 0) ? RegWr : 5'($urandom_range(0, 31));
            rR2     = ($urandom_range(0, 3) == 0) ? RegWr : 5'($urandom_range(0, 31));
            step();
        end

        idle_inputs();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
